// File: rtl/reg_load_ctrl.sv
// Debug register loader: waits for CPU halt, strobes one write into the register file, PC or IR,
// then reads the value back through the readout mux and reports done/err status.
module reg_load_ctrl #(
  parameter int unsigned HALT_TIMEOUT = 1024,
  parameter int unsigned VERIFY_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_req,
  input  logic [1:0]  sel,
  input  logic [3:0]  reg_sel,
  input  logic [15:0] wr_data,
  input  logic        halted,
  input  logic [15:0] reg_data,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic        pc_we,
  output logic        ir_we,
  output logic [15:0] wr_bus,
  output logic [1:0]  rd_sel,
  output logic [3:0]  rd_reg_sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {StIdle, StWaitHalt, StWrite, StVerify, StFinish} state_e;

  localparam logic [31:0] HaltLast = 32'(HALT_TIMEOUT - 1);
  localparam logic [3:0]  VerLast  = 4'(VERIFY_LAT - 1);

  state_e      state_q;
  logic [1:0]  sel_q;
  logic [3:0]  reg_sel_q;
  logic [15:0] data_q;
  logic [31:0] halt_cnt_q;
  logic [3:0]  ver_cnt_q;

  logic addr_ok;
  logic tgt_rf, tgt_pc, tgt_ir;

  always_comb begin
    addr_ok = (sel == 2'b00) || ((sel == 2'b11) && (reg_sel[3:1] == 3'b111));
    tgt_rf  = (sel_q == 2'b00);
    tgt_pc  = (sel_q == 2'b11) && (reg_sel_q == 4'b1110);
    tgt_ir  = (sel_q == 2'b11) && (reg_sel_q == 4'b1111);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_q      <= 2'b00;
      reg_sel_q  <= 4'h0;
      data_q     <= 16'h0000;
      halt_cnt_q <= 32'd0;
      ver_cnt_q  <= 4'h0;
      rf_we      <= 1'b0;
      rf_waddr   <= 4'h0;
      pc_we      <= 1'b0;
      ir_we      <= 1'b0;
      wr_bus     <= 16'h0000;
      rd_sel     <= 2'b00;
      rd_reg_sel <= 4'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      rf_we <= 1'b0;
      pc_we <= 1'b0;
      ir_we <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_req) begin
            sel_q      <= sel;
            reg_sel_q  <= reg_sel;
            data_q     <= wr_data;
            halt_cnt_q <= 32'd0;
            busy       <= 1'b1;
            if (addr_ok) begin
              err_code <= 2'b00;
              state_q  <= StWaitHalt;
            end else begin
              err_code <= 2'b01;
              state_q  <= StFinish;
            end
          end
        end
        StWaitHalt: begin
          if (halted) begin
            rf_we   <= tgt_rf;
            pc_we   <= tgt_pc;
            ir_we   <= tgt_ir;
            wr_bus  <= data_q;
            if (tgt_rf) rf_waddr <= reg_sel_q;
            state_q <= StWrite;
          end else if ((HALT_TIMEOUT != 0) && (halt_cnt_q == HaltLast)) begin
            err_code <= 2'b10;
            done     <= 1'b1;
            err      <= 1'b1;
            state_q  <= StFinish;
          end else begin
            halt_cnt_q <= halt_cnt_q + 32'd1;
          end
        end
        StWrite: begin
          rd_sel     <= sel_q;
          rd_reg_sel <= reg_sel_q;
          ver_cnt_q  <= 4'h0;
          state_q    <= StVerify;
        end
        StVerify: begin
          if (ver_cnt_q == VerLast) begin
            rd_sel     <= 2'b00;
            rd_reg_sel <= 4'h0;
            done       <= 1'b1;
            if (reg_data == data_q) begin
              err_code <= 2'b00;
            end else begin
              err_code <= 2'b11;
              err      <= 1'b1;
            end
            state_q <= StFinish;
          end else begin
            ver_cnt_q <= ver_cnt_q + 4'h1;
          end
        end
        StFinish: begin
          // A bad-address request arrives here without done set; pulse it one cycle later.
          if (!done) begin
            done <= 1'b1;
            err  <= (err_code != 2'b00);
          end else begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_load_ctrl.sv
// Directed bench for reg_load_ctrl; a small target model echoes writes back as reg_data.
module tb_reg_load_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_req;
  logic [1:0]  sel;
  logic [3:0]  reg_sel;
  logic [15:0] wr_data;
  logic        halted;
  logic [15:0] reg_data;
  logic        rf_we, pc_we, ir_we;
  logic [3:0]  rf_waddr;
  logic [15:0] wr_bus;
  logic [1:0]  rd_sel;
  logic [3:0]  rd_reg_sel;
  logic        busy, done, err;
  logic [1:0]  err_code;

  int nvec  = 0;
  int nfail = 0;
  int rf_cnt = 0, pc_cnt = 0, ir_cnt = 0, done_cnt = 0;
  int rf0, pc0, ir0;

  logic [15:0] rf_mem [16];
  logic [15:0] pc_mem, ir_mem;
  logic        corrupt;

  always #5 clk = ~clk;

  reg_load_ctrl #(
    .HALT_TIMEOUT (8),
    .VERIFY_LAT   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_req     (wr_req),
    .sel        (sel),
    .reg_sel    (reg_sel),
    .wr_data    (wr_data),
    .halted     (halted),
    .reg_data   (reg_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .wr_bus     (wr_bus),
    .rd_sel     (rd_sel),
    .rd_reg_sel (rd_reg_sel),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  // Target model: captures strobed writes, serves the readout mux address.
  always @(negedge clk) begin
    if (rf_we) begin rf_mem[rf_waddr] = wr_bus; rf_cnt++; end
    if (pc_we) begin pc_mem = wr_bus; pc_cnt++; end
    if (ir_we) begin ir_mem = wr_bus; ir_cnt++; end
    if (done) done_cnt++;
  end

  always_comb begin
    reg_data = 16'h0000;
    if (rd_sel == 2'b00) reg_data = rf_mem[rd_reg_sel];
    else if (rd_sel == 2'b11 && rd_reg_sel == 4'hE) reg_data = pc_mem;
    else if (rd_sel == 2'b11 && rd_reg_sel == 4'hF) reg_data = ir_mem;
    if (corrupt) reg_data = 16'h1234;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request edge, then scrambles the inputs to prove only latched copies are used.
  task automatic request(input logic [1:0] s, input logic [3:0] r, input logic [15:0] d);
    sel = s; reg_sel = r; wr_data = d; wr_req = 1'b1;
    step();
    wr_req = 1'b0; sel = ~s; reg_sel = ~r; wr_data = ~d;
  endtask

  task automatic snap();
    rf0 = rf_cnt; pc0 = pc_cnt; ir0 = ir_cnt;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 16'h0000;
    pc_mem = 16'h0000; ir_mem = 16'h0000; corrupt = 1'b0;
    reset = 1'b1; wr_req = 1'b0; sel = 2'b00; reg_sel = 4'h0; wr_data = 16'h0; halted = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_errcode", err_code, 0);
    chk("rst_strobes", {rf_we, pc_we, ir_we}, 0);
    chk("rst_wrbus", wr_bus, 0);
    chk("rst_rdaddr", {rd_sel, rd_reg_sel}, 0);

    // Register file write, echoed back
    snap();
    request(2'b00, 4'h3, 16'hA5A5);
    chk("rf_busy", busy, 1);
    chk("rf_nostrobe_n", rf_we, 0);
    step();
    chk("rf_we", rf_we, 1);
    chk("rf_waddr", rf_waddr, 3);
    chk("rf_wrbus", wr_bus, 16'hA5A5);
    chk("rf_other_we", {pc_we, ir_we}, 0);
    step();
    chk("rf_we_off", rf_we, 0);
    chk("rf_rdaddr", {rd_sel, rd_reg_sel}, 6'b00_0011);
    chk("rf_done_early", done, 0);
    step();
    chk("rf_done", done, 1);
    chk("rf_err", {err, err_code}, 0);
    step();
    chk("rf_done_off", done, 0);
    chk("rf_idle", busy, 0);
    chk("rf_count", rf_cnt - rf0, 1);

    // PC load
    snap();
    request(2'b11, 4'hE, 16'h0040);
    step();
    chk("pc_we", pc_we, 1);
    chk("pc_others", {rf_we, ir_we}, 0);
    step();
    chk("pc_rdaddr", {rd_sel, rd_reg_sel}, 6'b11_1110);
    step();
    chk("pc_done", {done, err, err_code}, 4'b1000);
    step();
    chk("pc_counts", {8'(rf_cnt - rf0), 8'(pc_cnt - pc0), 8'(ir_cnt - ir0)}, 24'h000100);

    // IR load; halted drops right after the strobe and must not abort
    snap();
    request(2'b11, 4'hF, 16'h0BEE);
    step();
    chk("ir_we", ir_we, 1);
    halted = 1'b0;
    step();
    chk("ir_rdaddr", {rd_sel, rd_reg_sel}, 6'b11_1111);
    step();
    chk("ir_done", {done, err, err_code}, 4'b1000);
    step();
    halted = 1'b1;
    chk("ir_counts", {8'(rf_cnt - rf0), 8'(pc_cnt - pc0), 8'(ir_cnt - ir0)}, 24'h000001);

    // Bad address
    snap();
    request(2'b01, 4'h1, 16'hFFFF);
    chk("bad_nodone_n", done, 0);
    step();
    chk("bad_done", {done, err, err_code}, 4'b1101);
    step();
    chk("bad_idle", {busy, done}, 0);
    chk("bad_nostrobe", (rf_cnt - rf0) + (pc_cnt - pc0) + (ir_cnt - ir0), 0);

    // Halt timeout, then retry with halted
    snap();
    halted = 1'b0;
    request(2'b00, 4'h5, 16'h1111);
    for (int i = 0; i < 7; i++) step();
    chk("to_wait", {busy, done}, 2'b10);
    step();
    chk("to_done", {done, err, err_code}, 4'b1110);
    step();
    chk("to_nostrobe", rf_cnt - rf0, 0);
    chk("to_hold", err_code, 2'b10);
    halted = 1'b1;
    request(2'b00, 4'h5, 16'h1111);
    chk("retry_clr", err_code, 0);
    step(); step(); step();
    chk("retry_done", {done, err, err_code}, 4'b1000);
    step();

    // Readback mismatch
    corrupt = 1'b1;
    request(2'b00, 4'h7, 16'h4321);
    step(); step(); step();
    chk("mis_done", {done, err, err_code}, 4'b1111);
    step(); step(); step();
    corrupt = 1'b0;
    chk("mis_hold", {busy, err_code}, 3'b011);

    // Reset during WAIT_HALT
    snap();
    halted = 1'b0;
    request(2'b00, 4'h2, 16'hBEEF);
    step();
    reset = 1'b1;
    halted = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_idle", {busy, done, rf_we, err_code}, 0);
    step(); step(); step();
    chk("rw_nostrobe", {busy, done, 8'(rf_cnt - rf0)}, 0);

    // Reset while in WRITE
    snap();
    request(2'b00, 4'h2, 16'hCAFE);
    step();
    chk("rwr_we", rf_we, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rwr_idle", {busy, done, rf_we, rd_sel, rd_reg_sel, wr_bus}, 0);
    step(); step(); step();
    chk("rwr_nodone", {busy, done}, 0);

    // Request while busy is ignored
    snap();
    halted = 1'b0;
    request(2'b00, 4'h9, 16'h1357);
    sel = 2'b11; reg_sel = 4'hE; wr_data = 16'h0000; wr_req = 1'b1;
    step();
    wr_req = 1'b0; halted = 1'b1;
    step();
    chk("bz_we", {rf_we, rf_waddr, wr_bus}, {1'b1, 4'h9, 16'h1357});
    step(); step();
    chk("bz_done", {done, err, err_code}, 4'b1000);
    step(); step(); step();
    chk("bz_counts", {busy, 8'(rf_cnt - rf0), 8'(pc_cnt - pc0), 8'(ir_cnt - ir0)},
        {1'b0, 24'h010000});
    chk("done_total", done_cnt, 8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
